// File: rtl/mul_unit.sv
// Iterative shift-add 32x32 multiplier with optional accumulate (MUL / MLA).
// One multiplier bit per ITER cycle; FIN presents the registered result with a one-cycle DONE.
module mul_unit #(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        Clk,
   input  logic        RESET,
   input  logic [31:0] Rm,
   input  logic [31:0] Rs,
   input  logic [31:0] Rn,
   input  logic        START,
   input  logic        ACC,
   output logic [31:0] Rd,
   output logic        BUSY,
   output logic        DONE,
   output logic        N,
   output logic        Z
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2
   } stateT;

   stateT       state;
   stateT       stateNext;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [4:0]  cnt;
   logic [31:0] accStep;
   logic        lastStep;

   assign accStep = mplier[0] ? (acc + mcand) : acc;

   // Decided on the pre-shift multiplier: the shifted value is zero when bits [31:1] are.
   assign lastStep = (cnt == 5'd31) || (EARLY_TERM && (mplier[31:1] == 31'd0));

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (START) stateNext = ITER;
         ITER:    if (lastStep) stateNext = FIN;
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state == ITER);
      DONE = (state == FIN);
   end

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         cnt    <= 5'd0;
         Rd     <= 32'd0;
         N      <= 1'b0;
         Z      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  acc    <= ACC ? Rn : 32'd0;
                  mcand  <= Rm;
                  mplier <= Rs;
                  cnt    <= 5'd0;
               end
            end
            ITER: begin
               acc    <= accStep;
               mcand  <= {mcand[30:0], 1'b0};
               mplier <= {1'b0, mplier[31:1]};
               cnt    <= cnt + 5'd1;
               // Result flags are loaded together with Rd on the step that enters FIN.
               if (lastStep) begin
                  Rd <= accStep;
                  N  <= accStep[31];
                  Z  <= (accStep == 32'd0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Randomized and directed checks of mul_unit, both EARLY_TERM settings driven in parallel
// and compared against a plain-arithmetic reference (product, addend, iteration count).
module tb_mul_unit;

   logic        Clk = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] Rm = 32'd0;
   logic [31:0] Rs = 32'd0;
   logic [31:0] Rn = 32'd0;
   logic        START = 1'b0;
   logic        ACC = 1'b0;

   logic [31:0] rdV [2];
   logic [1:0]  busyV;
   logic [1:0]  doneV;
   logic [1:0]  nV;
   logic [1:0]  zV;

   int testCount = 0;
   int failCount = 0;

   always #5 Clk = ~Clk;

   // Index 0: early termination; index 1: fixed 32 iterations.
   mul_unit #(.EARLY_TERM(1'b1)) dutEarly (
      .Clk(Clk), .RESET(RESET), .Rm(Rm), .Rs(Rs), .Rn(Rn), .START(START), .ACC(ACC),
      .Rd(rdV[0]), .BUSY(busyV[0]), .DONE(doneV[0]), .N(nV[0]), .Z(zV[0])
   );

   mul_unit #(.EARLY_TERM(1'b0)) dutFull (
      .Clk(Clk), .RESET(RESET), .Rm(Rm), .Rs(Rs), .Rn(Rn), .START(START), .ACC(ACC),
      .Rd(rdV[1]), .BUSY(busyV[1]), .DONE(doneV[1]), .N(nV[1]), .Z(zV[1])
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int iterCount(input logic [31:0] rs, input bit early);
      int n;
      if (!early) return 32;
      n = 1;
      for (int b = 0; b < 32; b++) if (rs[b]) n = b + 1;
      return n;
   endfunction

   task automatic scramble();
      Rm  = $urandom;
      Rs  = $urandom;
      Rn  = $urandom;
      ACC = 1'($urandom);
   endtask

   task automatic runOp(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                        input logic acc, input string tag);
      logic [31:0] expRes;
      logic [31:0] prevRd [2];
      int          nIter [2];
      int          seqErr [2];
      int          holdErr [2];
      expRes = rm * rs;
      if (acc) expRes = expRes + rn;
      nIter[0] = iterCount(rs, 1'b1);
      nIter[1] = iterCount(rs, 1'b0);
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
         prevRd[i]  = rdV[i];
         seqErr[i]  = 0;
         holdErr[i] = 0;
      end
      Rm = rm; Rs = rs; Rn = rn; ACC = acc; START = 1'b1;
      @(posedge Clk);
      #1;
      START = 1'b0;
      scramble();
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge Clk);
         scramble();
         for (int i = 0; i < 2; i++) begin
            if (busyV[i] !== (cyc <= nIter[i])) seqErr[i]++;
            if (doneV[i] !== (cyc == nIter[i] + 1)) seqErr[i]++;
            if (cyc <= nIter[i] && rdV[i] !== prevRd[i]) holdErr[i]++;
            if (cyc == nIter[i] + 1) begin
               checkVal($sformatf("%s rd%0d", tag, i), rdV[i], expRes);
               checkVal($sformatf("%s n%0d", tag, i), 32'(nV[i]), 32'(expRes[31]));
               checkVal($sformatf("%s z%0d", tag, i), 32'(zV[i]), 32'(expRes == 32'd0));
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         checkVal($sformatf("%s timing%0d", tag, i), 32'(seqErr[i]), 32'd0);
         checkVal($sformatf("%s rdhold%0d", tag, i), 32'(holdErr[i]), 32'd0);
      end
      $display("[TB] %s rm=%08h rs=%08h rn=%08h acc=%0d exp=%08h iters=%0d/%0d", tag, rm, rs, rn,
               acc, expRes, nIter[0], nIter[1]);
   endtask

   task automatic checkResetState(input string tag);
      for (int i = 0; i < 2; i++) begin
         checkVal($sformatf("%s rd%0d", tag, i), rdV[i], 32'd0);
         checkVal($sformatf("%s flags%0d", tag, i), {28'd0, busyV[i], doneV[i], nV[i], zV[i]},
                  32'h1);
      end
   endtask

   initial begin
      logic [31:0] rmR;
      logic [31:0] rsR;
      int          doneCyc;
      int          spurious;
      bit          idleBoth;

      // Asynchronous reset before any clock edge.
      #1 RESET = 1'b1;
      #1 checkResetState("reset");
      $display("[TB] reset asserted, outputs checked");
      repeat (2) @(negedge Clk);
      RESET = 1'b0;

      runOp(32'd3, 32'd5, 32'd0, 1'b0, "mul3x5");
      runOp(32'd7, 32'd6, 32'd100, 1'b1, "mla7x6+100");
      runOp(32'd0, 32'd0, 32'd0, 1'b1, "mla0");
      runOp(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "msb");
      runOp(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "rs1");

      for (int t = 0; t < 20; t++) begin
         rmR = $urandom;
         rsR = $urandom >> $urandom_range(0, 31);
         runOp(rmR, rsR, $urandom, 1'($urandom), $sformatf("rand%0d", t));
      end

      // START held high with operands changing: one result, then one IDLE cycle before restart.
      @(negedge Clk);
      Rm = 32'd9; Rs = 32'h13; Rn = 32'd55; ACC = 1'b0; START = 1'b1;
      @(posedge Clk);
      #1 scramble();
      doneCyc = 0;
      for (int cyc = 1; cyc <= 40 && doneCyc == 0; cyc++) begin
         @(negedge Clk);
         if (doneV[0]) doneCyc = cyc;
         else scramble();
      end
      checkVal("hold donecyc", 32'(doneCyc), 32'd6);
      checkVal("hold rd", rdV[0], 32'd171);
      @(negedge Clk);
      checkVal("hold idlegap", {30'd0, busyV[0], doneV[0]}, 32'd0);
      @(negedge Clk);
      checkVal("hold restart", 32'(busyV[0]), 32'd1);
      START = 1'b0;
      idleBoth = 1'b0;
      for (int cyc = 0; cyc < 80 && !idleBoth; cyc++) begin
         @(negedge Clk);
         idleBoth = (busyV == 2'b00) && (doneV == 2'b00);
      end
      checkVal("hold drain", 32'(idleBoth), 32'd1);
      $display("[TB] held-START sequence done at cycle %0d", doneCyc);

      // Reset in the middle of ITER: immediate clear, no DONE afterwards.
      @(negedge Clk);
      Rm = 32'd3; Rs = 32'hFFFF; Rn = 32'd0; ACC = 1'b0; START = 1'b1;
      @(posedge Clk);
      #1 START = 1'b0;
      repeat (5) @(negedge Clk);
      #2 RESET = 1'b1;
      #1 checkResetState("midreset");
      @(negedge Clk);
      RESET = 1'b0;
      spurious = 0;
      repeat (20) begin
         @(negedge Clk);
         if (doneV != 2'b00 || busyV != 2'b00) spurious++;
      end
      checkVal("midreset nodone", 32'(spurious), 32'd0);
      $display("[TB] mid-ITER reset checked");
      runOp(32'd2, 32'd2, 32'd0, 1'b0, "after-reset");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter EARLY_TERM, default 1; 1 = iteration stops when the remaining multiplier is zero, 0 = always 32 iterations.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 Rm  input  32  multiplicand; register-file Rm read port.
REQ-005 Rs  input  32  multiplier; register-file Rs read port.
REQ-006 Rn  input  32  accumulate addend; register-file Rn read port.
REQ-007 START  input  1  operation request; sampled only in IDLE.
REQ-008 ACC  input  1  1 = MLA (Rm*Rs+Rn), 0 = MUL (Rm*Rs); sampled with START.
REQ-009 Rd  output  32  registered result; drives the register-file Rd write bus.
REQ-010 BUSY  output  1  high while iterating.
REQ-011 DONE  output  1  one-cycle pulse: Rd holds a new result; the control unit uses it as the register-file LOAD.
REQ-012 N  output  1  Rd[31], registered with Rd.
REQ-013 Z  output  1  1 when Rd == 0, registered with Rd.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, ITER and FIN, with IDLE as the reset state.
REQ-015 In IDLE with START=1, the next edge SHALL capture the operands and enter ITER:
- acc = ACC ? Rn : 0
- mcand = Rm
- mplier = Rs
- cnt = 0
REQ-016 In IDLE with START=0, the block SHALL hold all state.
REQ-017 Each ITER cycle SHALL perform one step:
- if mplier[0], acc = acc + mcand, modulo 2^32
- mcand = mcand << 1
- mplier = mplier >> 1
- cnt = cnt + 1
REQ-018 ITER SHALL go to FIN after the step in which either condition holds:
- cnt reaches 31, or
- EARLY_TERM=1 and the shifted mplier is 0.
Otherwise it stays in ITER.
REQ-019 With EARLY_TERM=1, the number of ITER cycles SHALL be the index of the highest set bit of Rs plus 1, with a minimum of 1 (Rs=0 gives 1).
REQ-020 With EARLY_TERM=0, the number of ITER cycles SHALL be 32.
REQ-021 On entry to FIN, the block SHALL register Rd = acc, N = acc[31] and Z = (acc == 0).
REQ-022 In FIN the block SHALL assert DONE for exactly one cycle and then return to IDLE.
REQ-023 BUSY SHALL equal 1 exactly in ITER; DONE SHALL equal 1 exactly in FIN.
REQ-024 Latency: if START is sampled at edge k and the operation takes n ITER cycles, then BUSY is high for cycles k+1..k+n and DONE is high in cycle k+n+1.
REQ-025 START in ITER or FIN SHALL be ignored and not queued.
REQ-026 The earliest next accept SHALL be the edge that leaves FIN only if START is then sampled in IDLE; back-to-back operations therefore need one IDLE cycle.
REQ-027 Rm, Rs, Rn and ACC changes after capture SHALL NOT affect the operation in flight.
REQ-028 Rd, N and Z SHALL hold their last value until the next FIN entry; they SHALL NOT change during ITER.
REQ-029 The result SHALL be the low 32 bits of the product (plus addend for MLA); overflow is discarded silently, and operands are treated as unsigned (the low 32 bits are identical for signed operands).

Reset
REQ-030 RESET=1 SHALL immediately, without waiting for a clock edge, force the following:
- state IDLE
- Rd = 0, N = 0, Z = 1
- BUSY = 0, DONE = 0
- acc, mcand, mplier and cnt cleared
REQ-031 RESET asserted mid-ITER or in FIN SHALL abort the operation with no DONE pulse and no Rd update.
REQ-032 After RESET deasserts, the first rising edge with START=1 SHALL be accepted normally.

Verification
REQ-033 MUL, Rm=3, Rs=5, ACC=0, START at edge 0 -> BUSY high for cycles 1-3; DONE in cycle 4; Rd=15, N=0, Z=0.
REQ-034 MLA, Rm=7, Rs=6, Rn=100, ACC=1 -> 3 ITER cycles; Rd=142; then Rm=0, Rs=0, Rn=0, ACC=1 -> 1 ITER cycle; Rd=0, Z=1.
REQ-035 Rm=0xFFFFFFFF, Rs=0x80000000, ACC=0 -> 32 ITER cycles; Rd=0x80000000, N=1; with EARLY_TERM=0 and Rs=1 -> also 32 ITER cycles; Rd=0xFFFFFFFF.
REQ-036 START held high and operands changed during ITER and FIN -> the single result is from the captured operands; the second operation starts only after one IDLE cycle.
REQ-037 RESET pulsed in the middle of ITER (Rs=0xFFFF) -> Rd=0, Z=1, BUSY=0 and no DONE, all without a clock edge; a following MUL of 2*2 gives Rd=4.
